// File: rtl/inv_key_schedule.sv
// AES-128 round-key generator for decryption: expands the cipher key forward to K10, then
// streams K10..K0 over valid/ready using the inverse schedule step. Option: INV_KEY_CACHE_EN.
module inv_key_schedule (
    input  logic         pi_clk,
    input  logic         pi_rst_n,
    input  logic [127:0] pi_cipher_key,
    input  logic         pi_start,
    input  logic         pi_abort,
    input  logic         pi_key_ready,
    output logic [127:0] po_round_key,
    output logic [3:0]   po_round_idx,
    output logic         po_key_valid,
    output logic         po_busy,
    output logic         po_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_EMIT} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3, inv_w3;
    logic [31:0]  sub_in, rot_in, sub_out, new_w0;
    logic [31:0]  f1, f2, f3;
    logic [7:0]   rc;
    logic [127:0] fwd_key, inv_key, hit_key;
    logic         start_ok, accept, last_fwd, cache_hit;

    assign {w0, w1, w2, w3} = key_q;
    assign inv_w3 = w3 ^ w2;

    // One 4-byte S-box bank: fed by w3 when expanding, by the recovered w3' when emitting.
    assign sub_in = (state_q == ST_EMIT) ? inv_w3 : w3;
    assign rot_in = {sub_in[23:0], sub_in[31:24]};
    assign rc     = rcon((state_q == ST_EMIT) ? cnt_q : cnt_q + 4'd1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_out[gi*8 +: 8] = sbox(rot_in[gi*8 +: 8]);
        end
    endgenerate

    // The new w0 has the same form in both directions; only the S-box input differs.
    assign new_w0  = w0 ^ sub_out ^ {rc, 24'h000000};
    assign f1      = w1 ^ new_w0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign fwd_key = {new_w0, f1, f2, f3};
    assign inv_key = {new_w0, w1 ^ w0, w2 ^ w1, inv_w3};

    // A start is not re-armed during the done-pulse cycle.
    assign start_ok = (state_q == ST_IDLE) && pi_start && !done_q;
    assign accept   = (state_q == ST_EMIT) && pi_key_ready && !pi_abort;
    assign last_fwd = (state_q == ST_EXPAND) && !pi_abort && (cnt_q == 4'd9);

`ifdef INV_KEY_CACHE_EN
    logic [127:0] pend_key_q, cache_key_q, cache_k10_q;
    logic         cache_vld_q;

    assign cache_hit = cache_vld_q && (pi_cipher_key == cache_key_q);
    assign hit_key   = cache_k10_q;

    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            pend_key_q  <= '0;
            cache_key_q <= '0;
            cache_k10_q <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            if (start_ok) begin
                pend_key_q <= pi_cipher_key;
            end
            if (last_fwd) begin
                cache_key_q <= pend_key_q;
                cache_k10_q <= fwd_key;
                cache_vld_q <= 1'b1;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_key   = '0;
`endif

    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = cache_hit ? ST_EMIT : ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (pi_abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd9) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (pi_abort) begin
                    state_d = ST_IDLE;
                end else if (accept && (cnt_q == 4'd0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        po_key_valid = (state_q == ST_EMIT);
        po_busy      = (state_q != ST_IDLE);
    end

    always_comb begin
        key_d  = key_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    key_d = cache_hit ? hit_key : pi_cipher_key;
                    cnt_d = cache_hit ? 4'd10 : 4'd0;
                end
            end
            ST_EXPAND: begin
                if (!pi_abort) begin
                    key_d = fwd_key;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_EMIT: begin
                if (accept) begin
                    if (cnt_q == 4'd0) begin
                        done_d = 1'b1;
                    end else begin
                        key_d = inv_key;
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            key_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            key_q  <= key_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign po_round_key = key_q;
    assign po_round_idx = cnt_q;
    assign po_done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule: reference keys come from a textbook AES-128 expansion
// with a GF(2^8)-derived S-box; a negedge monitor pops and compares every accepted key.
`timescale 1ns/1ps
module tb_inv_key_schedule;

`ifdef INV_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] cipher_key = '0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         key_ready = 1'b1;
    logic [127:0] po_round_key;
    logic [3:0]   po_round_idx;
    logic         po_key_valid;
    logic         po_busy;
    logic         po_done;

    always #5 clk = ~clk;

    inv_key_schedule dut (
        .pi_clk        (clk),
        .pi_rst_n      (rst_n),
        .pi_cipher_key (cipher_key),
        .pi_start      (start),
        .pi_abort      (abort),
        .pi_key_ready  (key_ready),
        .po_round_key  (po_round_key),
        .po_round_idx  (po_round_idx),
        .po_key_valid  (po_key_valid),
        .po_busy       (po_busy),
        .po_done       (po_done)
    );

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   idx;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    int           done_exp = 0;
    int           acc_cnt = 0;
    logic [7:0]   sb [256];
    logic [127:0] mk [11];
    logic [127:0] acc_key [11];
    logic         held_v = 1'b0;
    logic [127:0] held_key;
    logic [3:0]   held_idx;
    logic [127:0] cache_key_m = '0;
    bit           cache_ok_m = 1'b0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: compares each accepted key, checks stability under backpressure, counts done pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v && po_key_valid) begin
                chk("hold_key", po_round_key, held_key);
                chk("hold_idx", 128'(po_round_idx), 128'(held_idx));
            end
            held_v   = po_key_valid && !key_ready && !abort;
            held_key = po_round_key;
            held_idx = po_round_idx;
            if (po_key_valid && key_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key actual idx=%0d key=%h required none", po_round_idx, po_round_key);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("round_key", po_round_key, mon_e.key);
                    chk("round_idx", 128'(po_round_idx), 128'(mon_e.idx));
                end
                acc_key[po_round_idx] = po_round_key;
                acc_cnt++;
                $display("accept idx=%0d key=%h", po_round_idx, po_round_key);
            end
            if (po_done) done_cnt++;
        end
    end

    // One full start..done (or abort) transaction.
    task automatic run_seq(input logic [127:0] k, input bit rnd_rdy, input int stall_idx,
                           input int abort_idx, input bit abort_rdy, input bit poke,
                           input bit done_start);
        int  lat;
        int  n;
        bit  hit;
        bit  stalled;
        exp_t e;
        model_expand(k);
        hit = CACHE_EN && cache_ok_m && (k == cache_key_m);
        acc_cnt = 0;
        for (int r = 10; r >= 0; r--) begin
            e.key = mk[r];
            e.idx = 4'(r);
            exp_q.push_back(e);
        end
        key_ready  = 1'b1;
        cipher_key = k;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        cipher_key = rand_key();
        // lat = edges after the sampling edge until valid is seen
        lat = 0;
        while (!po_key_valid && lat < 40) begin
            if (poke && lat == 3) begin
                cipher_key = ~k;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        chk("latency", 128'(lat), hit ? 128'd0 : 128'd10);
        if (!po_key_valid) begin
            exp_q.delete();
            return;
        end
        if (!hit) begin
            cache_key_m = k;
            cache_ok_m  = 1'b1;
        end
        n = 0;
        stalled = 1'b0;
        while (!po_done && n < 100) begin
            if (abort_idx >= 0 && po_round_idx == 4'(abort_idx)) begin
                abort = 1'b1;
                key_ready = abort_rdy;
                tick();
                abort = 1'b0;
                key_ready = 1'b1;
                exp_q.delete();
                chk("abort_valid", 128'(po_key_valid), 128'd0);
                chk("abort_busy", 128'(po_busy), 128'd0);
                chk("abort_done", 128'(po_done), 128'd0);
                chk("abort_idx_kept", 128'(po_round_idx), 128'(abort_idx));
                chk("abort_key_kept", po_round_key, mk[abort_idx]);
                tick();
                chk("abort_done_cnt", 128'(done_cnt), 128'(done_exp));
                return;
            end
            if (stall_idx >= 0 && !stalled && po_round_idx == 4'(stall_idx)) begin
                key_ready = 1'b0;
                repeat (3) tick();
                n += 3;
                key_ready = 1'b1;
                stalled = 1'b1;
                continue;
            end
            key_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (poke && po_round_idx == 4'd4) begin
                cipher_key = rand_key();
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            n++;
        end
        chk("done_seen", 128'(po_done), 128'd1);
        if (!rnd_rdy) chk("emit_cycles", 128'(n), (stall_idx >= 0) ? 128'd14 : 128'd11);
        chk("accept_count", 128'(acc_cnt), 128'd11);
        chk("queue_empty", 128'(exp_q.size()), 128'd0);
        exp_q.delete();
        key_ready = 1'b1;
        if (done_start) begin
            cipher_key = rand_key();
            start = 1'b1;
        end
        tick();
        start = 1'b0;
        done_exp++;
        chk("done_pulse_cnt", 128'(done_cnt), 128'(done_exp));
        chk("done_one_cycle", 128'(po_done), 128'd0);
        chk("idle_busy", 128'(po_busy), 128'd0);
    endtask

    initial begin
        logic [127:0] ka;
        logic [127:0] kb;
        build_sbox();
        repeat (2) tick();
        chk("rst_key", po_round_key, 128'd0);
        chk("rst_idx", 128'(po_round_idx), 128'd0);
        chk("rst_valid", 128'(po_key_valid), 128'd0);
        chk("rst_busy", 128'(po_busy), 128'd0);
        chk("rst_done", 128'(po_done), 128'd0);
        rst_n = 1'b1;
        tick();

        run_seq(FIPS_KEY, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);
        chk("fips_k10", acc_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_k1", acc_key[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_k0", acc_key[0], FIPS_KEY);
        run_seq(FIPS_KEY, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);

        run_seq(rand_key(), 1'b0, 5, -1, 1'b0, 1'b0, 1'b0);
        run_seq(rand_key(), 1'b0, -1, 7, 1'b0, 1'b0, 1'b0);
        ka = rand_key();
        run_seq(ka, 1'b0, -1, 7, 1'b1, 1'b0, 1'b0);
        run_seq(rand_key(), 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);
        ka = rand_key();
        run_seq(ka, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);

        // abort mid-expansion with a different key, then the previous key again
        kb = rand_key();
        cipher_key = kb;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("xabort_busy", 128'(po_busy), 128'd0);
        chk("xabort_valid", 128'(po_key_valid), 128'd0);
        tick();
        chk("xabort_done_cnt", 128'(done_cnt), 128'(done_exp));
        run_seq(ka, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);

        run_seq(rand_key(), 1'b0, -1, -1, 1'b0, 1'b1, 1'b0);
        run_seq(rand_key(), 1'b0, -1, -1, 1'b0, 1'b0, 1'b1);
        ka = rand_key();
        run_seq(ka, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);

        // reset in the middle of expansion
        cipher_key = rand_key();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_key", po_round_key, 128'd0);
        chk("midrst_idx", 128'(po_round_idx), 128'd0);
        chk("midrst_valid", 128'(po_key_valid), 128'd0);
        chk("midrst_busy", 128'(po_busy), 128'd0);
        chk("midrst_done", 128'(po_done), 128'd0);
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        cache_ok_m = 1'b0;
        tick();
        chk("postrst_busy", 128'(po_busy), 128'd0);
        chk("postrst_valid", 128'(po_key_valid), 128'd0);
        run_seq(ka, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_seq(rand_key(), 1'b1, -1, -1, 1'b0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
